// File: rtl/pga_gain_ctrl_if.sv
// -----------------------------------------------------------------------------
// pga_gain_ctrl_if
//   Handshake bundle between the automatic gain controller and the PGA serial
//   interface block.
//
//   code_o      : gain code presented to the PGA interface (controller drives)
//   set_o       : one-cycle write strobe (controller drives)
//   pga_ready_i : PGA interface idle (PGA interface drives)
//
//   master : gain controller side
//   slave  : PGA serial interface side
// -----------------------------------------------------------------------------
interface pga_gain_ctrl_if;
  logic [7:0] code_o;
  logic       set_o;
  logic       pga_ready_i;

  modport master (
    output code_o,
    output set_o,
    input  pga_ready_i
  );

  modport slave (
    input  code_o,
    input  set_o,
    output pga_ready_i
  );
endinterface

// File: rtl/pga_gain_ctrl.sv
// -----------------------------------------------------------------------------
// pga_gain_ctrl
//   Automatic gain controller in front of the PGA serial interface. It tracks
//   the peak absolute sample amplitude over a window of WINDOW valid samples.
//   It then steps the 8-bit gain code down (signal too loud) or up (signal too
//   quiet) and programs each new code through the code/set/ready handshake.
//   After reset INIT_CODE is programmed unconditionally.
//
// Ports
//   sck            : clock, all logic on the rising edge
//   rst_n          : asynchronous active-low reset
//   enable_i       : 1 = automatic adjustment enabled
//   sample_i       : signed two's-complement sample
//   sample_valid_i : sample_i valid this cycle
//   pga            : PGA handshake (code_o / set_o out, pga_ready_i in)
//   gain_o         : last code confirmed written to the PGA
//   gain_valid_o   : gain_o meaningful (at least one write completed)
//   busy_o         : a PGA write is in progress
// -----------------------------------------------------------------------------
module pga_gain_ctrl #(
  parameter int         SAMPLE_W  = 16,
  parameter int         WINDOW    = 256,
  parameter int         HIGH_TH   = 24576,
  parameter int         LOW_TH    = 8192,
  parameter logic [7:0] STEP      = 8'd1,
  parameter logic [7:0] CODE_MIN  = 8'h00,
  parameter logic [7:0] CODE_MAX  = 8'h8F,
  parameter logic [7:0] INIT_CODE = 8'h40
) (
  input  logic                       sck,
  input  logic                       rst_n,
  input  logic                       enable_i,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  input  logic                       sample_valid_i,
  pga_gain_ctrl_if.master            pga,
  output logic [7:0]                 gain_o,
  output logic                       gain_valid_o,
  output logic                       busy_o
);

  typedef enum logic [2:0] {
    ST_ACCUM   = 3'd0,
    ST_DECIDE  = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_WAIT_HI = 3'd4
  } state_t;

  localparam int                  CNT_W     = $clog2(WINDOW);
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0]    CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
  localparam logic [SAMPLE_W-2:0] PEAK_ZERO = (SAMPLE_W-1)'(0);
  localparam logic [SAMPLE_W-1:0] HIGH_V    = SAMPLE_W'(HIGH_TH);
  localparam logic [SAMPLE_W-1:0] LOW_V     = SAMPLE_W'(LOW_TH);

  // Absolute value of a two's-complement sample, saturating the most
  // negative value (whose negation does not fit) to the largest magnitude.
  function automatic logic [SAMPLE_W-2:0] abs_sat(input logic [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] neg;
    neg = ~s + {{(SAMPLE_W-1){1'b0}}, 1'b1};
    if (!s[SAMPLE_W-1]) begin
      abs_sat = s[SAMPLE_W-2:0];
    end else if (neg[SAMPLE_W-1]) begin
      abs_sat = {(SAMPLE_W-1){1'b1}};
    end else begin
      abs_sat = neg[SAMPLE_W-2:0];
    end
  endfunction

  state_t              r_state;
  logic [7:0]          r_code;
  logic                r_set;
  logic [7:0]          r_gain;
  logic                r_gain_valid;
  logic                r_busy;
  logic [SAMPLE_W-2:0] r_peak;
  logic [CNT_W-1:0]    r_cnt;

  logic [SAMPLE_W-2:0] w_mag;
  logic [SAMPLE_W-2:0] w_peak_next;
  logic [8:0]          w_dn;
  logic [8:0]          w_up;
  logic [7:0]          w_new_code;

  // Sample magnitude, running peak and the next gain code candidate.
  always_comb begin
    w_mag       = abs_sat(sample_i);
    w_peak_next = r_peak;
    w_new_code  = r_gain;
    // 9-bit arithmetic: bit 8 of w_dn flags an underflow, bit 8 of w_up an
    // overflow past 255, so both clamps remain correct for any STEP.
    w_dn        = {1'b0, r_gain} - {1'b0, STEP};
    w_up        = {1'b0, r_gain} + {1'b0, STEP};

    if (w_mag > r_peak) begin
      w_peak_next = w_mag;
    end else begin
      w_peak_next = r_peak;
    end

    if ({1'b0, r_peak} > HIGH_V) begin
      if (w_dn[8] || (w_dn[7:0] < CODE_MIN)) begin
        w_new_code = CODE_MIN;
      end else begin
        w_new_code = w_dn[7:0];
      end
    end else if ({1'b0, r_peak} < LOW_V) begin
      if (w_up > {1'b0, CODE_MAX}) begin
        w_new_code = CODE_MAX;
      end else begin
        w_new_code = w_up[7:0];
      end
    end else begin
      w_new_code = r_gain;
    end
  end

  // Control FSM: measure a window, decide, then run the PGA write handshake.
  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_ISSUE;
      r_code       <= INIT_CODE;
      r_set        <= 1'b0;
      r_gain       <= INIT_CODE;
      r_gain_valid <= 1'b0;
      r_busy       <= 1'b1;
      r_peak       <= PEAK_ZERO;
      r_cnt        <= CNT_ZERO;
    end else begin
      // The strobe is only ever raised for the single cycle after ISSUE.
      r_set <= 1'b0;
      case (r_state)
        ST_ACCUM: begin
          if (sample_valid_i) begin
            r_peak <= w_peak_next;
            if (r_cnt == CNT_LAST) begin
              r_cnt   <= CNT_ZERO;
              r_state <= ST_DECIDE;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
        end
        ST_DECIDE: begin
          if (!enable_i || (w_new_code == r_gain)) begin
            r_peak  <= PEAK_ZERO;
            r_state <= ST_ACCUM;
          end else begin
            r_code  <= w_new_code;
            r_busy  <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (pga.pga_ready_i) begin
            r_set   <= 1'b1;
            r_state <= ST_WAIT_LO;
          end
        end
        ST_WAIT_LO: begin
          // Wait for the PGA interface to acknowledge by dropping ready.
          if (!pga.pga_ready_i) begin
            r_state <= ST_WAIT_HI;
          end
        end
        ST_WAIT_HI: begin
          if (pga.pga_ready_i) begin
            r_gain       <= r_code;
            r_gain_valid <= 1'b1;
            r_peak       <= PEAK_ZERO;
            r_cnt        <= CNT_ZERO;
            r_busy       <= 1'b0;
            r_state      <= ST_ACCUM;
          end
        end
        default: begin
          // Illegal encoding: recover by reprogramming the current code.
          r_peak  <= PEAK_ZERO;
          r_cnt   <= CNT_ZERO;
          r_busy  <= 1'b1;
          r_state <= ST_ISSUE;
        end
      endcase
    end
  end

  assign pga.code_o   = r_code;
  assign pga.set_o    = r_set;
  assign gain_o       = r_gain;
  assign gain_valid_o = r_gain_valid;
  assign busy_o       = r_busy;

endmodule

// File: tb/tb_pga_gain_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pga_gain_ctrl
//   Directed bench for pga_gain_ctrl with default parameters. A small PGA
//   interface model answers each set strobe (ready low for a few cycles, then
//   high). A gain model predicts every window's outcome from the peak/threshold
//   rules. A monitor thread compares the DUT outputs with the model on every
//   falling edge.
// -----------------------------------------------------------------------------
module tb_pga_gain_ctrl;
  localparam int WIN       = 256;
  localparam int HIGH      = 24576;
  localparam int LOW       = 8192;
  localparam int CMIN      = 0;
  localparam int CMAX      = 143;
  localparam int INIT      = 64;
  localparam int BUSY_LEN  = 3;

  logic               sck            = 1'b0;
  logic               rst_n          = 1'b0;
  logic               enable_i       = 1'b1;
  logic signed [15:0] sample_i       = 16'sd0;
  logic               sample_valid_i = 1'b0;
  logic [7:0]         gain_o;
  logic               gain_valid_o;
  logic               busy_o;

  logic               ready_int      = 1'b1;
  logic               hold_low       = 1'b0;

  pga_gain_ctrl_if u_if ();
  assign u_if.pga_ready_i = ready_int & ~hold_low;

  pga_gain_ctrl u_dut (
    .sck            (sck),
    .rst_n          (rst_n),
    .enable_i       (enable_i),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .pga            (u_if),
    .gain_o         (gain_o),
    .gain_valid_o   (gain_valid_o),
    .busy_o         (busy_o)
  );

  always #5 sck = ~sck;

  int checks     = 0;
  int failures   = 0;
  int m_gain     = INIT;
  bit m_valid    = 1'b0;
  bit exp_armed  = 1'b1;
  int exp_code   = INIT;
  int inflight   = INIT;
  bit prev_set   = 1'b0;
  int ph         = 0;
  int pcnt       = 0;
  int drop_delay = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Gain rule: loud -> one step down, quiet -> one step up, clamped.
  function automatic int model_code(input int peak, input int gain);
    if (peak > HIGH) return (gain - 1 < CMIN) ? CMIN : gain - 1;
    else if (peak < LOW) return (gain + 1 > CMAX) ? CMAX : gain + 1;
    else return gain;
  endfunction

  // Per-cycle comparison against the model, followed by the PGA model step.
  task automatic monitor();
    forever begin
      @(negedge sck);
      if (!rst_n) begin
        m_gain    = INIT;
        m_valid   = 1'b0;
        exp_armed = 1'b1;
        exp_code  = INIT;
        prev_set  = 1'b0;
        ph        = 0;
        ready_int = 1'b1;
      end else begin
        if (u_if.set_o) begin
          chk("set_expected", int'(exp_armed), 1);
          chk("set_code", int'(u_if.code_o), exp_code);
          chk("set_while_ready", int'(u_if.pga_ready_i), 1);
          chk("set_single_cycle", int'(prev_set), 0);
          inflight  = exp_code;
          exp_armed = 1'b0;
        end
        chk("gain", int'(gain_o), m_gain);
        chk("gain_valid", int'(gain_valid_o), int'(m_valid));
        prev_set = u_if.set_o;
        if (u_if.set_o) begin
          if (drop_delay == 0) begin
            ph = 2; pcnt = BUSY_LEN; ready_int = 1'b0;
          end else begin
            ph = 1; pcnt = drop_delay;
          end
        end else if (ph == 1) begin
          pcnt--;
          if (pcnt == 0) begin
            ph = 2; pcnt = BUSY_LEN; ready_int = 1'b0;
          end
        end else if (ph == 2) begin
          pcnt--;
          if (pcnt == 0) begin
            ph = 0; ready_int = 1'b1; m_gain = inflight; m_valid = 1'b1;
          end
        end
      end
    end
  endtask

  // kind 0: constant, 1: alternating +/-val, 2: val at index 100, zero elsewhere.
  task automatic send_window(input int kind, input int val, input bit lat, output bit wr);
    int peak;
    int s;
    int a;
    int nc;
    peak = 0;
    wr   = 1'b0;
    for (int i = 0; i < WIN; i++) begin
      if (kind == 0) s = val;
      else if (kind == 1) s = ((i % 2) == 0) ? val : -val;
      else s = (i == 100) ? val : 0;
      a = (s < 0) ? -s : s;
      if (a > 32767) a = 32767;
      if (a > peak) peak = a;
      @(negedge sck); #1;
      sample_i       = 16'(s);
      sample_valid_i = 1'b1;
    end
    @(negedge sck); #1;
    sample_valid_i = 1'b0;
    sample_i       = 16'sd0;
    nc = model_code(peak, m_gain);
    if (enable_i && (nc != m_gain)) begin
      exp_code  = nc;
      exp_armed = 1'b1;
      wr        = 1'b1;
    end
    if (lat) begin
      @(negedge sck);
      @(negedge sck); #1;
      chk("strobe_latency", int'(u_if.set_o), 1);
    end
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge sck); #1;
      done = !exp_armed && (ph == 0) && !busy_o;
    end
    chk("write_done", int'(done), 1);
  endtask

  task automatic settle();
    repeat (3) @(negedge sck);
    #1;
    chk("idle_not_busy", int'(busy_o), 0);
  endtask

  task automatic window_and_finish(input int kind, input int val);
    bit wr;
    send_window(kind, val, 1'b0, wr);
    if (wr) wait_done();
    else settle();
  endtask

  task automatic check_reset_values();
    chk("rst_code", int'(u_if.code_o), 8'h40);
    chk("rst_set", int'(u_if.set_o), 0);
    chk("rst_gain", int'(gain_o), 8'h40);
    chk("rst_gain_valid", int'(gain_valid_o), 0);
    chk("rst_busy", int'(busy_o), 1);
  endtask

  task automatic do_reset();
    @(negedge sck); #1;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    repeat (2) @(negedge sck);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit wr;
    bit seen;
    fork
      monitor();
    join_none

    // Reset release with an idle PGA: INIT_CODE is programmed once.
    repeat (3) @(negedge sck);
    #1;
    check_reset_values();
    rst_n = 1'b1;
    wait_done();
    chk("init_gain", int'(gain_o), 8'h40);
    chk("init_valid", int'(gain_valid_o), 1);
    chk("init_busy", int'(busy_o), 0);

    // Loud windows: step down, then clamp at the minimum.
    send_window(0, 30000, 1'b1, wr);
    wait_done();
    chk("down_first", int'(gain_o), 8'h3F);
    for (int i = 0; i < 64; i++) window_and_finish(0, 30000);
    chk("down_clamp", int'(gain_o), 8'h00);

    // Between thresholds: no write.
    window_and_finish(0, 16000);
    chk("mid_unchanged", int'(gain_o), 8'h00);

    // Quiet windows from INIT_CODE: step up, then clamp at the maximum.
    do_reset();
    wait_done();
    send_window(1, 1000, 1'b0, wr);
    wait_done();
    chk("up_first", int'(gain_o), 8'h41);
    for (int i = 0; i < 79; i++) window_and_finish(1, 1000);
    chk("up_clamp", int'(gain_o), 8'h8F);

    // Single most-negative sample saturates to 32767 and is loud.
    window_and_finish(2, -32768);
    chk("neg_full_scale", int'(gain_o), 8'h8E);

    // Disabled: loud input produces no write.
    enable_i = 1'b0;
    window_and_finish(0, 30000);
    chk("disabled_gain", int'(gain_o), 8'h8E);
    enable_i = 1'b1;

    // PGA never ready: no strobe, busy held.
    hold_low = 1'b1;
    send_window(0, 30000, 1'b0, wr);
    repeat (3) @(negedge sck);
    for (int i = 0; i < 40; i++) begin
      @(negedge sck); #1;
      chk("hold_no_set", int'(u_if.set_o), 0);
      chk("hold_busy", int'(busy_o), 1);
    end
    hold_low = 1'b0;
    wait_done();
    chk("hold_then_write", int'(gain_o), 8'h8D);

    // Reset while waiting for ready to fall after the strobe.
    drop_delay = 4;
    send_window(0, 30000, 1'b0, wr);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge sck); #1;
      seen = u_if.set_o;
    end
    chk("midwrite_strobe_seen", int'(seen), 1);
    @(negedge sck); #1;
    chk("midwrite_busy", int'(busy_o), 1);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    repeat (2) @(negedge sck);
    #1;
    rst_n      = 1'b1;
    drop_delay = 0;
    wait_done();
    chk("rewrite_gain", int'(gain_o), 8'h40);
    chk("rewrite_valid", int'(gain_valid_o), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
